// File: rtl/l1_instr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l1_instr_pkg
// Description : Shared types, widths and address-slice helpers for the
//               L1 instruction refill controller.
// Revision    : 1.0 - initial release
// ============================================================================
package l1_instr_pkg;

    localparam int c_tag_size    = 9;
    localparam int c_idx_size    = 6;
    localparam int c_word_size   = 2;
    localparam int c_offset_size = 1;
    localparam int c_addr_w      = c_tag_size + c_idx_size + c_word_size + c_offset_size;
    localparam int c_line_w      = c_tag_size + c_idx_size;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        L2_REQ,
        FILL_START,
        FILL,
        NEXT_REQ,
        NEXT_FILL,
        RESPOND
    } state_t;

    // Fetch address layout, MSB first: {tag, idx, word, offset}
    function automatic logic [c_tag_size-1:0] addr_tag(input logic [c_addr_w-1:0] a);
        return a[c_addr_w-1 -: c_tag_size];
    endfunction

    function automatic logic [c_idx_size-1:0] addr_idx(input logic [c_addr_w-1:0] a);
        return a[c_word_size+c_offset_size +: c_idx_size];
    endfunction

    function automatic logic [c_word_size-1:0] addr_word(input logic [c_addr_w-1:0] a);
        return a[c_offset_size +: c_word_size];
    endfunction

    function automatic logic [c_offset_size-1:0] addr_offset(input logic [c_addr_w-1:0] a);
        return a[c_offset_size-1:0];
    endfunction

    function automatic logic [c_line_w-1:0] addr_line(input logic [c_addr_w-1:0] a);
        return {addr_tag(a), addr_idx(a)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/l1_instr_refill_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with increment enable that holds at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/l1_instr_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : l1_instr_refill_ctrl
// Description : Fetch-side controller for the two-way L1 I-cache; refills
//               missing primary and spill-over lines from L2.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_instr_refill_ctrl
    import l1_instr_pkg::*;
#(
    parameter int block_size  = 128,
    parameter int tag_size    = 9,
    parameter int idx_size    = 6,
    parameter int word_size   = 2,
    parameter int offset_size = 1
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic                                             fetch_req_i,
    input  logic [tag_size+idx_size+word_size+offset_size-1:0] fetch_addr_i,
    output logic                                             fetch_ready_o,
    output logic                                             fetch_valid_o,
    output logic [31:0]                                      fetch_data_o,
    output logic                                             cache_read_o,
    output logic                                             cache_write_o,
    output logic                                             cache_instr_write_start_o,
    output logic                                             cache_write_next_o,
    output logic [tag_size+idx_size+word_size+offset_size-1:0] cache_addr_o,
    output logic [block_size-1:0]                            cache_block_o,
    input  logic [31:0]                                      cache_data_i,
    input  logic                                             cache_hit_i,
    input  logic                                             cache_miss_next_i,
    output logic                                             l2_req_o,
    output logic [tag_size+idx_size-1:0]                     l2_addr_o,
    input  logic                                             l2_ready_i,
    input  logic [block_size-1:0]                            l2_data_i,
    output logic [15:0]                                      hit_cnt_o,
    output logic [15:0]                                      miss_cnt_o
);

    localparam int c_a  = tag_size + idx_size + word_size + offset_size;
    localparam int c_lw = tag_size + idx_size;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_a-1:0]      r_addr_q;
    logic [block_size-1:0] r_line_buf;
    logic                r_refill;
    logic [31:0]         r_fetch_data;
    logic [c_lw-1:0]     w_line;
    logic                w_hit_inc;
    logic                w_miss_inc;
    logic                w_clean_hit;

    assign w_line      = addr_line(r_addr_q);
    assign w_clean_hit = cache_hit_i & ~cache_miss_next_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state              = r_state;
        fetch_ready_o             = 1'b0;
        fetch_valid_o             = 1'b0;
        cache_read_o              = 1'b0;
        cache_write_o             = 1'b0;
        cache_instr_write_start_o = 1'b0;
        cache_write_next_o        = 1'b0;
        cache_addr_o              = '0;
        cache_block_o             = '0;
        l2_req_o                  = 1'b0;
        l2_addr_o                 = '0;
        w_hit_inc                 = 1'b0;
        w_miss_inc                = 1'b0;

        case (r_state)
            IDLE: begin
                fetch_ready_o = 1'b1;
                if (fetch_req_i) w_next_state = LOOKUP;
            end
            LOOKUP: begin
                cache_read_o = 1'b1;
                cache_addr_o = r_addr_q;
                if (w_clean_hit)       w_next_state = RESPOND;
                else if (!cache_hit_i) w_next_state = L2_REQ;
                else                   w_next_state = NEXT_REQ;
            end
            L2_REQ: begin
                l2_req_o  = 1'b1;
                l2_addr_o = w_line;
                if (l2_ready_i) begin
                    w_miss_inc   = 1'b1;
                    w_next_state = FILL_START;
                end
            end
            FILL_START: begin
                cache_instr_write_start_o = 1'b1;
                w_next_state              = FILL;
            end
            FILL: begin
                cache_write_o = 1'b1;
                cache_addr_o  = r_addr_q;
                cache_block_o = r_line_buf;
                w_next_state  = LOOKUP;
            end
            NEXT_REQ: begin
                // Line after the spilling one; idx overflow carries into tag, top wraps to 0
                l2_req_o  = 1'b1;
                l2_addr_o = w_line + 1'b1;
                if (l2_ready_i) begin
                    w_miss_inc   = 1'b1;
                    w_next_state = NEXT_FILL;
                end
            end
            NEXT_FILL: begin
                cache_write_o      = 1'b1;
                cache_write_next_o = 1'b1;
                cache_addr_o       = r_addr_q;
                cache_block_o      = r_line_buf;
                w_next_state       = LOOKUP;
            end
            RESPOND: begin
                fetch_valid_o = 1'b1;
                w_hit_inc     = ~r_refill;
                w_next_state  = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr_q     <= '0;
            r_line_buf   <= '0;
            r_refill     <= 1'b0;
            r_fetch_data <= '0;
        end else begin
            if ((r_state == IDLE) && fetch_req_i) begin
                r_addr_q <= fetch_addr_i;
                r_refill <= 1'b0;
            end
            if (((r_state == L2_REQ) || (r_state == NEXT_REQ)) && l2_ready_i) begin
                r_line_buf <= l2_data_i;
            end
            if ((r_state == FILL) || (r_state == NEXT_FILL)) begin
                r_refill <= 1'b1;
            end
            if ((r_state == LOOKUP) && w_clean_hit) begin
                r_fetch_data <= cache_data_i;
            end
        end
    end

    assign fetch_data_o = r_fetch_data;

    sat_counter #(.WIDTH(16)) u_hit_cnt (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_inc   (w_hit_inc),
        .o_count (hit_cnt_o)
    );

    sat_counter #(.WIDTH(16)) u_miss_cnt (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_inc   (w_miss_inc),
        .o_count (miss_cnt_o)
    );

endmodule
`default_nettype wire
